// File: rtl/coprime_pair_scanner.sv
// Sweep controller around a combinational coprime checker: walks every (a,b)
// pair within the latched bounds and streams out the pairs the checker flags.
module coprime_pair_scanner #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_max,
  input  logic [WIDTH-1:0]   b_max,
  output logic [WIDTH-1:0]   chk_a,
  output logic [WIDTH-1:0]   chk_b,
  input  logic               chk_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_a,
  output logic [WIDTH-1:0]   out_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] pair_count
);

  // state   | meaning
  // S_IDLE  | waiting for start; bounds and count latched on accept
  // S_PROBE | chk_a/chk_b on checker, verdict sampled at end of cycle
  // S_EMIT  | flagged pair held on out_a/out_b until out_ready
  // S_DONE  | one-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_EMIT, S_DONE} state_t;

  localparam logic [WIDTH-1:0]   OP_ONE  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] CNT_ONE = (2*WIDTH)'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_max_q, b_max_q;
  logic             last_pair;
  logic             bound_zero;
  logic             advance;

  assign last_pair  = (chk_a == a_max_q) && (chk_b == b_max_q);
  assign bound_zero = (a_max == '0) || (b_max == '0);
  assign advance    = ((state == S_PROBE) && !chk_result) ||
                      ((state == S_EMIT) && out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = bound_zero ? S_DONE : S_PROBE;
      S_PROBE: begin
        if (chk_result)     state_nxt = S_EMIT;
        else if (last_pair) state_nxt = S_DONE;
      end
      S_EMIT:  if (out_ready) state_nxt = last_pair ? S_DONE : S_PROBE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_max_q    <= '0;
      b_max_q    <= '0;
      chk_a      <= '0;
      chk_b      <= '0;
      out_a      <= '0;
      out_b      <= '0;
      pair_count <= '0;
    end else begin
      if ((state == S_IDLE) && start) begin
        a_max_q    <= a_max;
        b_max_q    <= b_max;
        pair_count <= '0;
        chk_a      <= OP_ONE;
        chk_b      <= OP_ONE;
      end
      if ((state == S_PROBE) && chk_result) begin
        out_a      <= chk_a;
        out_b      <= chk_b;
        pair_count <= pair_count + CNT_ONE;
      end
      // The final pair is left in place so the operands never run past the bounds.
      if (advance && !last_pair) begin
        if (chk_b == b_max_q) begin
          chk_b <= OP_ONE;
          chk_a <= chk_a + OP_ONE;
        end else begin
          chk_b <= chk_b + OP_ONE;
        end
      end
    end
  end

  assign out_valid = (state == S_EMIT);
  assign busy      = (state == S_PROBE) || (state == S_EMIT);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_coprime_pair_scanner.sv
// Bench for coprime_pair_scanner: directed and randomized sweeps checked against
// an expected pair list built from nested loops over the bounds.
module tb_coprime_pair_scanner;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a_max, b_max;
  logic [W-1:0]   chk_a, chk_b;
  logic           chk_result;
  logic           out_valid, out_ready;
  logic [W-1:0]   out_a, out_b;
  logic           busy, done;
  logic [2*W-1:0] pair_count;

  int compared = 0;
  int mismatched = 0;
  int mode = 0;   // 0: real checker, 1: always flag

  coprime_pair_scanner #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_max(a_max), .b_max(b_max),
    .chk_a(chk_a), .chk_b(chk_b), .chk_result(chk_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .busy(busy), .done(done), .pair_count(pair_count)
  );

  always #5 clk = ~clk;

  // Checker model, including its quirk of flagging equal operands as 0.
  function automatic bit coprime_model(input int a, input int b);
    int x, y, t;
    if (a == b) return 1'b0;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return (x == 1);
  endfunction

  always_comb chk_result = (mode == 1) ? 1'b1 : coprime_model(int'(chk_a), int'(chk_b));

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_sweep(input string tag, input int amax, input int bmax,
                           input int m, input int pct, input bit disturb);
    int exp_q[$];
    int got_q[$];
    int cyc, busy_cnt, done_cnt, done_cyc, n_pairs;
    bit prev_stall;
    int prev_pair;
    mode = m;
    for (int a = 1; a <= amax; a++)
      for (int b = 1; b <= bmax; b++)
        if (m == 1 || coprime_model(a, b)) exp_q.push_back(a * 16 + b);
    n_pairs = amax * bmax;

    @(negedge clk);
    a_max = W'(amax); b_max = W'(bmax); start = 1'b1;
    out_ready = (pct >= 100) || ($urandom_range(0, 99) < pct);
    @(posedge clk); #1 start = 1'b0;
    cyc = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    prev_stall = 1'b0; prev_pair = 0;
    while (cyc < 4000 && done_cyc < 0) begin
      @(negedge clk); cyc++;
      if (prev_stall) begin
        check({tag, "_hold_valid"}, int'(out_valid), 1);
        check({tag, "_hold_pair"}, int'({out_a, out_b}), prev_pair);
      end
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (out_valid && out_ready) got_q.push_back(int'({out_a, out_b}));
      prev_stall = out_valid && !out_ready;
      prev_pair  = int'({out_a, out_b});
      @(posedge clk); #1;
      out_ready = (pct >= 100) || ($urandom_range(0, 99) < pct);
      if (disturb) begin
        if (cyc == 4) begin start = 1'b1; a_max = W'(7); b_max = W'(1); end
        if (cyc == 5) start = 1'b0;
      end
    end
    check({tag, "_done_seen"}, int'(done_cyc > 0), 1);
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_emit_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_pair%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_pair_count"}, int'(pair_count), exp_q.size());
    if (pct >= 100) begin
      check({tag, "_busy_cycles"}, busy_cnt, n_pairs + exp_q.size());
      check({tag, "_done_after_busy"}, done_cyc, busy_cnt + 1);
    end
  endtask

  initial begin
    int wait_cyc;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; a_max = '0; b_max = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rst_chk_a", int'(chk_a), 0);
    check("rst_chk_b", int'(chk_b), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pair_count", int'(pair_count), 0);

    run_sweep("t1", 3, 3, 0, 100, 1'b0);
    run_sweep("t2", 3, 3, 0, 30, 1'b0);
    run_sweep("t3", 0, 5, 0, 100, 1'b0);
    run_sweep("t4", 15, 15, 1, 100, 1'b0);
    check("t4_last_a", int'(out_a), 15);
    check("t4_last_b", int'(out_b), 15);
    check("t4_chk_a_nowrap", int'(chk_a), 15);
    check("t4_chk_b_nowrap", int'(chk_b), 15);
    run_sweep("t5", 4, 3, 0, 100, 1'b1);

    // Reset asserted while a pair is waiting on the stream.
    @(negedge clk);
    mode = 0; a_max = 3; b_max = 3; start = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    wait_cyc = 0;
    while (!out_valid && wait_cyc < 20) begin @(posedge clk); #1; wait_cyc++; end
    check("t6_pre_valid", int'(out_valid), 1);
    rst_n = 1'b0; #1;
    check("t6_rst_valid", int'(out_valid), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_done", int'(done), 0);
    check("t6_rst_out_a", int'(out_a), 0);
    check("t6_rst_out_b", int'(out_b), 0);
    check("t6_rst_chk_a", int'(chk_a), 0);
    check("t6_rst_count", int'(pair_count), 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    run_sweep("t6", 3, 3, 0, 100, 1'b0);

    for (int k = 0; k < 4; k++)
      run_sweep($sformatf("rnd%0d", k), $urandom_range(0, 6), $urandom_range(0, 6),
                0, $urandom_range(30, 100), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
